// File: rtl/mux4_arbiter.sv
// Round-robin owner arbiter for four 1-bit requesters sharing one line through a mux4.
// Grant latency is 1 cycle and out is combinational; requesters keep req high until granted.

module mux4 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] sel,
  output logic       y
);
  always_comb begin
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end
endmodule

module mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] data,
  output logic [3:0] grant,
  output logic [1:0] control,
  output logic       valid,
  output logic       out
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] control_q, control_d;
  logic       valid_q, valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;

  logic [3:0] others;
  logic [1:0] next_ptr;
  logic [1:0] pick_idle;
  logic [1:0] pick_next;
  logic       release_own;
  logic       mux_y;

  // Highest-priority set bit starting at p and wrapping; lower k overrides higher k.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign others      = req & ~grant_q;
  assign next_ptr    = control_q + 2'd1;
  assign pick_idle   = rr_pick(req, ptr_q);
  assign pick_next   = rr_pick(others, next_ptr);
  assign release_own = !req[control_q] || ((hold_q == HOLD_MAX) && (|others));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    control_d = control_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d   = BUSY;
        control_d = pick_idle;
        grant_d   = 4'd1 << pick_idle;
        valid_d   = 1'b1;
        hold_d    = 4'd1;
      end
    end else begin
      if (release_own) begin
        ptr_d = next_ptr;
        // The released owner is masked out so it cannot win again while others wait.
        if (|others) begin
          control_d = pick_next;
          grant_d   = 4'd1 << pick_next;
          hold_d    = 4'd1;
        end else begin
          state_d = IDLE;
          grant_d = 4'd0;
          valid_d = 1'b0;
          hold_d  = 4'd0;
        end
      end else if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'd0;
      control_q <= 2'd0;
      valid_q   <= 1'b0;
      ptr_q     <= 2'd0;
      hold_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      control_q <= control_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  mux4 u_mux4 (
    .a   (data[0]),
    .b   (data[1]),
    .c   (data[2]),
    .d   (data[3]),
    .sel (control_q),
    .y   (mux_y)
  );

  assign out     = mux_y & valid_q;
  assign grant   = grant_q;
  assign control = control_q;
  assign valid   = valid_q;
endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: stimulus queues expected outputs from a round-robin model,
// a monitor pops and compares every cycle.

module tb_mux4_arbiter;
  localparam int MH = 4;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] c;
    logic       v;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] grant;
  logic [1:0] control;
  logic       valid;
  logic       out;

  int vectors = 0;
  int miscompares = 0;
  exp_t expq[$];

  int m_ctrl, m_ptr, m_held;
  bit m_valid;
  int waitc[4];

  mux4_arbiter #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .data    (data),
    .grant   (grant),
    .control (control),
    .valid   (valid),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_ctrl  = 0;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  // Ownership rules: first requester from ptr wins; owner leaves when it drops req
  // or has held MH cycles while someone else waits; ptr moves past the leaving owner.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    bit rel;
    if (!m_valid) begin
      if (r != 4'd0) begin
        m_ctrl  = first_from(r, m_ptr);
        m_valid = 1;
        m_held  = 1;
      end
    end else begin
      others = r;
      others[m_ctrl] = 1'b0;
      rel = !r[m_ctrl] || (m_held == MH && others != 4'd0);
      if (rel) begin
        m_ptr = (m_ctrl + 1) % 4;
        if (others != 4'd0) begin
          m_ctrl = first_from(others, m_ptr);
          m_held = 1;
        end else begin
          m_valid = 0;
          m_held  = 0;
        end
      end else if (m_held < MH) begin
        m_held++;
      end
    end
  endtask

  function automatic logic [3:0] exp_grant();
    return m_valid ? (4'd1 << m_ctrl) : 4'd0;
  endfunction

  task automatic step(input logic [3:0] r, input logic [3:0] d, input bit rst);
    exp_t e;
    @(negedge clk);
    if (rst) begin
      #1 reset_n = 1'b0;
      model_reset();
      #1 chk("async_reset", {grant, control, valid, out}, 8'h00);
      #1 reset_n = 1'b1;
    end
    req  = r;
    data = d;
    #1 chk("comb_out", {7'd0, out}, {7'd0, m_valid & d[m_ctrl]});
    model_step(r);
    e.g = exp_grant();
    e.c = 2'(m_ctrl);
    e.v = m_valid;
    e.o = m_valid & d[m_ctrl];
    expq.push_back(e);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("grant",   {4'd0, grant},   {4'd0, e.g});
        chk("control", {6'd0, control}, {6'd0, e.c});
        chk("valid",   {7'd0, valid},   {7'd0, e.v});
        chk("out",     {7'd0, out},     {7'd0, e.o});
        chk("onehot0", {7'd0, $onehot0(grant)}, 8'd1);
        vectors++;
        for (int i = 0; i < 4; i++) begin
          if (req[i] && !grant[i]) waitc[i]++;
          else waitc[i] = 0;
          if (waitc[i] > 3 * MH) begin
            miscompares++;
            $display("FAIL starvation: requester %0d waited %0d cycles, limit %0d", i, waitc[i], 3 * MH);
            waitc[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    reset_n = 1'b0;
    req     = 4'd0;
    data    = 4'd0;
    #1 chk("reset_state", {grant, control, valid, out}, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester 2, then data change drops out in the same cycle
    step(4'b0100, 4'b0100, 0);
    step(4'b0100, 4'b0000, 0);
    step(4'b0000, 4'b0000, 0);

    // Full contention from reset: owners 0,1,2,3,0 each for MH cycles
    step(4'b1111, 4'($urandom), 1);
    repeat (20) step(4'b1111, 4'($urandom), 0);

    // Voluntary release to idle, then ptr=1 search wraps back to requester 0
    step(4'b0001, 4'b0001, 1);
    step(4'b0001, 4'b0001, 0);
    step(4'b0000, 4'b0001, 0);
    step(4'b0001, 4'b0001, 0);

    // Requester 3 alone past saturation, then requester 1 preempts
    repeat (10) step(4'b1000, 4'($urandom), 0);
    step(4'b1010, 4'b0010, 0);

    // Async reset while requester 1 owns; ptr=0 search picks bit 1 again
    step(4'b1010, 4'b0010, 1);
    step(4'b1010, 4'b0010, 0);

    r = 4'd0;
    repeat (3000) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      step(r, 4'($urandom), 0);
    end

    step(4'b0000, 4'b0000, 0);
    @(posedge clk);
    #2 chk("drain", 8'(expq.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive granted cycles for one requester while another requester is waiting (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per requester; bit i = requester i.
REQ-005 data  input  4  1-bit data per requester; bit i = requester i's data.
REQ-006 grant  output  4  one-hot grant to current owner; all zero when idle.
REQ-007 control  output  2  owner index, driven as mux4 select (00=A/req0 .. 11=D/req3).
REQ-008 valid  output  1  high while a requester owns the shared line.
REQ-009 out  output  1  shared output: data[control] when valid, else 0.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner = control).
REQ-011 The datapath SHALL be one mux4 instance (A..D = data[0..3], control as select), its output ANDed with valid to form out; out is combinational from data, all other outputs are registered.
REQ-012 Round-robin pointer ptr (2 bits) SHALL name the highest-priority requester; search order ptr, ptr+1, ptr+2, ptr+3, modulo 4 (3 wraps to 0).
REQ-013 IDLE, req==0: remain IDLE, grant=0, valid=0.
REQ-014 IDLE, req!=0 sampled at edge: go BUSY at that edge, owner = first set bit in search order; grant latency exactly 1 cycle from req sampled high.
REQ-015 BUSY: hold_cnt (4 bits) SHALL count granted cycles of current owner, loaded to 1 on grant, incremented each cycle the grant is held, saturating at MAX_HOLD.
REQ-016 BUSY release SHALL occur at an edge where req[owner]==0 (voluntary) or where hold_cnt==MAX_HOLD and any other req bit is 1 (preemption).
REQ-017 BUSY, hold_cnt==MAX_HOLD, no other request: owner keeps grant indefinitely; hold_cnt stays saturated.
REQ-018 On release, ptr SHALL become owner+1 mod 4; arbitration for the same edge uses the updated ptr.
REQ-019 On release with another request pending: grant the next owner at that same edge (back-to-back, no idle cycle), hold_cnt=1, stay BUSY.
REQ-020 On release with no other request (voluntary only): go IDLE, grant=0, valid=0, control holds last owner.
REQ-021 A released owner whose req is still high SHALL NOT be re-granted while any other req bit is 1.
REQ-022 Requests arriving at non-owner positions during BUSY SHALL not affect grant until a release condition.
REQ-023 grant SHALL always be one-hot or zero; grant[control]==valid in every cycle.
REQ-024 MAX_HOLD=1: with contention, ownership rotates every cycle.

Reset
REQ-025 reset_n low SHALL immediately (no clock) force state=IDLE, grant=0000, control=00, valid=0, ptr=00, hold_cnt=0; out therefore 0.
REQ-026 reset_n asserted mid-BUSY SHALL abort ownership; first arbitration after deassertion uses ptr=00.
REQ-027 Deassertion SHALL be synchronised by the integrator; first active edge after release follows REQ-013/014.

Verification
REQ-028 Reset, then req=0100 held, data=0100 -> edge 1: grant=0100, control=10, valid=1, out=1; data=0000 -> out=0 same cycle.
REQ-029 req=1111 held, MAX_HOLD=4 from reset -> owners 0,1,2,3,0 each for exactly 4 cycles, no idle cycle between.
REQ-030 req=0001 owner, req[0] drops after 2 cycles, req=0000 -> IDLE next edge, grant=0000, valid=0, control=00; next req=0001 granted (ptr=01 wraps to 0).
REQ-031 Owner 3 alone for 10 cycles, MAX_HOLD=4 -> grant=1000 all 10 cycles; req[1] rises -> grant=0010 on next edge (hold_cnt saturated), ptr wrap 3->0 verified.
REQ-032 reset_n pulsed low between edges while grant=0010 -> grant=0000, valid=0, out=0 immediately; req=1010 after release -> grant=0010 (ptr=00 search: bit0 clear, bit1 first).
REQ-033 Every cycle of random req/data stimulus: grant one-hot-or-zero, out==(valid & data[control]), no requester starved beyond 3*MAX_HOLD cycles while requesting.
